// File: rtl/wbstage_if.sv
// ---------------------------------------------------------------------------
// wbstage_if : MEM/WB-to-writeback bundle plus the register-file write port.
//
// Signals
//   memtoregin  [1:0]      writeback select from MEM/WB
//   regwrin                register-write enable from MEM/WB
//   finin                  final-instruction flag from MEM/WB
//   regdstmuxin [4:0]      destination register number
//   aluoutin    [DWIDTH]   ALU result
//   dmdatain    [DWIDTH]   data-memory read data
//   pcnextin    [AWIDTH]   PC+4 of the instruction
//   negativein             ALU negative flag
//   insin       [31:0]     instruction word (32'h0 = bubble)
//   rfwe/rfwaddr/rfwdata   register-file write port (from the stage)
//
// Handshake: there is no valid/ready pair. MEM/WB presents one instruction
// per cycle; a non-zero insin marks it as real, insin==0 is a bubble. The
// register file samples rfwe/rfwaddr/rfwdata on the next posedge and can
// never stall the stage.
//
// Modports: master = MEM/WB side (drives the instruction, sees the write
// port), slave = the writeback stage.
// ---------------------------------------------------------------------------
interface wbstage_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
);
  logic [1:0]        memtoregin;
  logic              regwrin;
  logic              finin;
  logic [4:0]        regdstmuxin;
  logic [DWIDTH-1:0] aluoutin;
  logic [DWIDTH-1:0] dmdatain;
  logic [AWIDTH-1:0] pcnextin;
  logic              negativein;
  logic [31:0]       insin;
  logic              rfwe;
  logic [4:0]        rfwaddr;
  logic [DWIDTH-1:0] rfwdata;

  modport master (
    output memtoregin, regwrin, finin, regdstmuxin, aluoutin, dmdatain,
           pcnextin, negativein, insin,
    input  rfwe, rfwaddr, rfwdata
  );

  modport slave (
    input  memtoregin, regwrin, finin, regdstmuxin, aluoutin, dmdatain,
           pcnextin, negativein, insin,
    output rfwe, rfwaddr, rfwdata
  );
endinterface

// File: rtl/wbstage.sv
// ---------------------------------------------------------------------------
// wbstage : pipeline writeback stage.
//
// Selects the writeback value, drives the register-file write port (never
// writing $0, never writing a bubble, never writing once halted), keeps a
// one-entry bypass of the last committed write, counts retired instructions
// and stops the core after the fin instruction retires.
//
// Ports
//   clk, rstn      clock, asynchronous active-low reset
//   wb (slave)     MEM/WB inputs and combinational register-file write port
//   bypvalid/bypaddr/bypdata   last committed write (registered)
//   retcnt         retired-instruction count, wraps modulo 2^CWIDTH
//   halted         1 when the FSM is in HALT; this is the full FSM state
//
// Optional feature: define WB_TRACE_EN to add the registered retire trace
// outputs tracevalid/tracepc/traceins/tracewdata.
// ---------------------------------------------------------------------------
module wbstage #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32,
  parameter int CWIDTH = 32
) (
  input  logic              clk,
  input  logic              rstn,
  wbstage_if.slave          wb,
  output logic              bypvalid,
  output logic [4:0]        bypaddr,
  output logic [DWIDTH-1:0] bypdata,
  output logic [CWIDTH-1:0] retcnt,
`ifdef WB_TRACE_EN
  output logic              tracevalid,
  output logic [AWIDTH-1:0] tracepc,
  output logic [31:0]       traceins,
  output logic [DWIDTH-1:0] tracewdata,
`endif
  output logic              halted
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_e;

  state_e            state_q, state_d;
  logic              bypvalid_q, bypvalid_d;
  logic [4:0]        bypaddr_q, bypaddr_d;
  logic [DWIDTH-1:0] bypdata_q, bypdata_d;
  logic [CWIDTH-1:0] retcnt_q, retcnt_d;

  logic [DWIDTH-1:0] pc_ext;
  logic [DWIDTH-1:0] wdata;
  logic              retire;
  logic              we;

  // PC+4 fitted to the datapath: zero-extend when narrower, truncate when wider.
  generate
    if (AWIDTH < DWIDTH) begin : g_pc_zext
      assign pc_ext = {{(DWIDTH-AWIDTH){1'b0}}, wb.pcnextin};
    end else begin : g_pc_trunc
      assign pc_ext = wb.pcnextin[DWIDTH-1:0];
    end
  endgenerate

  always_comb begin
    wdata = wb.aluoutin;
    unique case (wb.memtoregin)
      2'b00: wdata = wb.aluoutin;
      2'b01: wdata = wb.dmdatain;
      2'b10: wdata = pc_ext;
      2'b11: wdata = {{(DWIDTH-1){1'b0}}, wb.negativein};
      default: wdata = wb.aluoutin;
    endcase
  end

  assign retire = (state_q == RUN) && (wb.insin != 32'h0);
  // A bubble never writes even if its regwrin bit is stale.
  assign we     = retire && wb.regwrin && (wb.regdstmuxin != 5'd0);

  assign wb.rfwe    = we;
  assign wb.rfwaddr = wb.regdstmuxin;
  assign wb.rfwdata = wdata;

  always_comb begin
    state_d    = state_q;
    bypvalid_d = we;
    bypaddr_d  = bypaddr_q;
    bypdata_d  = bypdata_q;
    retcnt_d   = retcnt_q;

    // fin enters HALT even when it arrives as a bubble.
    if (state_q == RUN && wb.finin) begin
      state_d = HALT;
    end
    if (we) begin
      bypaddr_d = wb.regdstmuxin;
      bypdata_d = wdata;
    end
    if (retire) begin
      retcnt_d = retcnt_q + CWIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= RUN;
      bypvalid_q <= 1'b0;
      bypaddr_q  <= 5'd0;
      bypdata_q  <= '0;
      retcnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      bypvalid_q <= bypvalid_d;
      bypaddr_q  <= bypaddr_d;
      bypdata_q  <= bypdata_d;
      retcnt_q   <= retcnt_d;
    end
  end

  assign bypvalid = bypvalid_q;
  assign bypaddr  = bypaddr_q;
  assign bypdata  = bypdata_q;
  assign retcnt   = retcnt_q;
  assign halted   = (state_q == HALT);

`ifdef WB_TRACE_EN
  logic              tracevalid_q, tracevalid_d;
  logic [AWIDTH-1:0] tracepc_q, tracepc_d;
  logic [31:0]       traceins_q, traceins_d;
  logic [DWIDTH-1:0] tracewdata_q, tracewdata_d;

  always_comb begin
    tracevalid_d = retire;
    tracepc_d    = tracepc_q;
    traceins_d   = traceins_q;
    tracewdata_d = tracewdata_q;
    if (retire) begin
      tracepc_d    = wb.pcnextin - AWIDTH'(4);
      traceins_d   = wb.insin;
      tracewdata_d = wdata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tracevalid_q <= 1'b0;
      tracepc_q    <= '0;
      traceins_q   <= '0;
      tracewdata_q <= '0;
    end else begin
      tracevalid_q <= tracevalid_d;
      tracepc_q    <= tracepc_d;
      traceins_q   <= traceins_d;
      tracewdata_q <= tracewdata_d;
    end
  end

  assign tracevalid = tracevalid_q;
  assign tracepc    = tracepc_q;
  assign traceins   = traceins_q;
  assign tracewdata = tracewdata_q;
`endif

endmodule

// File: tb/tb_wbstage.sv
// ---------------------------------------------------------------------------
// tb_wbstage : directed self-checking bench for wbstage.
// The DUT is built with CWIDTH=4 so the retire counter wrap is reachable.
// Inputs change 1 time unit after a posedge; combinational outputs are
// sampled before the next posedge, registered outputs 1 unit after it.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wbstage;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int CW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  wbstage_if #(.DWIDTH(DW), .AWIDTH(AW)) wb ();

  logic          bypvalid;
  logic [4:0]    bypaddr;
  logic [DW-1:0] bypdata;
  logic [CW-1:0] retcnt;
  logic          halted;
`ifdef WB_TRACE_EN
  logic          tracevalid;
  logic [AW-1:0] tracepc;
  logic [31:0]   traceins;
  logic [DW-1:0] tracewdata;
`endif

  wbstage #(.DWIDTH(DW), .AWIDTH(AW), .CWIDTH(CW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .wb         (wb),
    .bypvalid   (bypvalid),
    .bypaddr    (bypaddr),
    .bypdata    (bypdata),
    .retcnt     (retcnt),
`ifdef WB_TRACE_EN
    .tracevalid (tracevalid),
    .tracepc    (tracepc),
    .traceins   (traceins),
    .tracewdata (tracewdata),
`endif
    .halted     (halted)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [CW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic present(input logic [1:0] m2r, input logic rw, input logic fin,
                         input logic [4:0] dst, input logic [DW-1:0] alu,
                         input logic [DW-1:0] dm, input logic [AW-1:0] pc,
                         input logic neg, input logic [31:0] ins);
    wb.memtoregin  = m2r;
    wb.regwrin     = rw;
    wb.finin       = fin;
    wb.regdstmuxin = dst;
    wb.aluoutin    = alu;
    wb.dmdatain    = dm;
    wb.pcnextin    = pc;
    wb.negativein  = neg;
    wb.insin       = ins;
    #1;
  endtask

  task automatic idle();
    present(2'b00, 1'b0, 1'b0, 5'd0, '0, '0, '0, 1'b0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    idle();
    tick();
    @(negedge clk);
    rstn = 1'b1;
    tick();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [DW-1:0] rnd;
    logic [CW-1:0] exp_cnt;

    idle();
    tick();
    check("rst_halted", halted, 0);
    check("rst_retcnt", retcnt, 0);
    check("rst_bypvalid", bypvalid, 0);
    check("rst_bypaddr", bypaddr, 0);
    check("rst_bypdata", bypdata, 0);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    check("idle_rfwe", wb.rfwe, 0);

    // ALU write to r5
    present(2'b00, 1'b1, 1'b0, 5'd5, 32'h1234, 32'h0, 32'h4, 1'b0, 32'h00a52020);
    check("alu_rfwe", wb.rfwe, 1);
    check("alu_rfwaddr", wb.rfwaddr, 5);
    check("alu_rfwdata", wb.rfwdata, 32'h1234);
    tick();
    check("alu_bypvalid", bypvalid, 1);
    check("alu_bypaddr", bypaddr, 5);
    check("alu_bypdata", bypdata, 32'h1234);
    check("alu_retcnt", retcnt, 1);

    // memory load to r6
    present(2'b01, 1'b1, 1'b0, 5'd6, 32'h1111, 32'hDEADBEEF, 32'h8, 1'b0, 32'h8c060000);
    check("dm_rfwdata", wb.rfwdata, 32'hDEADBEEF);
    tick();
    check("dm_retcnt", retcnt, 2);
    check("dm_bypdata", bypdata, 32'hDEADBEEF);

    // link write to r31
    present(2'b10, 1'b1, 1'b0, 5'd31, 32'h1111, 32'h2222, 32'h40, 1'b0, 32'h0c000010);
    check("pc_rfwdata", wb.rfwdata, 32'h40);
    tick();
    check("pc_bypaddr", bypaddr, 31);
    check("pc_bypdata", bypdata, 32'h40);
    check("pc_retcnt", retcnt, 3);

    // set-on-negative to r7
    present(2'b11, 1'b1, 1'b0, 5'd7, 32'hFFFF_FFFF, 32'h2222, 32'h44, 1'b1, 32'h0000382a);
    check("neg_rfwdata", wb.rfwdata, 32'h1);
    tick();
    check("neg_retcnt", retcnt, 4);
    check("neg_bypdata", bypdata, 32'h1);

    // write to $0: no write, still retires, bypass address/data hold
    present(2'b00, 1'b1, 1'b0, 5'd0, 32'hFF, 32'h0, 32'h48, 1'b0, 32'h00000020);
    check("r0_rfwe", wb.rfwe, 0);
    tick();
    check("r0_bypvalid", bypvalid, 0);
    check("r0_bypaddr_hold", bypaddr, 7);
    check("r0_bypdata_hold", bypdata, 32'h1);
    check("r0_retcnt", retcnt, 5);

    // bubble
    idle();
    check("bub_rfwe", wb.rfwe, 0);
    tick();
    check("bub_retcnt", retcnt, 5);

    // non-writing real instruction still counts
    present(2'b00, 1'b0, 1'b0, 5'd3, 32'h33, 32'h0, 32'h4c, 1'b0, 32'hac030000);
    check("nowr_rfwe", wb.rfwe, 0);
    tick();
    check("nowr_retcnt", retcnt, 6);

    // fin writing r2
    present(2'b00, 1'b1, 1'b1, 5'd2, 32'h22, 32'h0, 32'h50, 1'b0, 32'hfc000000);
    check("fin_rfwe", wb.rfwe, 1);
    check("fin_rfwaddr", wb.rfwaddr, 2);
    check("fin_rfwdata", wb.rfwdata, 32'h22);
    check("fin_not_yet_halted", halted, 0);
    tick();
    check("fin_halted", halted, 1);
    check("fin_retcnt", retcnt, 7);
    check("fin_bypvalid", bypvalid, 1);
    check("fin_bypaddr", bypaddr, 2);

    // after halt: nothing writes or counts
    present(2'b00, 1'b1, 1'b0, 5'd9, 32'h99, 32'h0, 32'h54, 1'b0, 32'h00094820);
    check("hlt_rfwe", wb.rfwe, 0);
    tick();
    check("hlt_retcnt", retcnt, 7);
    check("hlt_bypvalid", bypvalid, 0);
    check("hlt_halted", halted, 1);
    tick();
    check("hlt_retcnt2", retcnt, 7);

    // asynchronous reset while halted, away from any clock edge
    #2;
    rstn = 1'b0;
    #1;
    check("arst_halted", halted, 0);
    check("arst_retcnt", retcnt, 0);
    check("arst_bypaddr", bypaddr, 0);
    check("arst_bypdata", bypdata, 0);
    idle();
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // fin arriving as a bubble: halts but does not count
    present(2'b00, 1'b0, 1'b1, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();
    check("finbub_halted", halted, 1);
    check("finbub_retcnt", retcnt, 0);

    // counter wrap: 16 retires from reset
    do_reset();
    check("wrap_start", retcnt, 0);
    exp_cnt = '0;
    for (int i = 0; i < 16; i++) begin
      rnd = DW'($urandom_range(32'h7fff_ffff, 1));
      present(2'b00, 1'b1, 1'b0, 5'(i % 31 + 1), rnd, 32'h0, 32'h1000 + 32'(4 * i),
              1'b0, 32'h2000_0000 | 32'(i));
      check("wrap_rfwdata", wb.rfwdata, rnd);
      exp_cnt = exp_cnt + 1'b1;
      exp_q.push_back(exp_cnt);
      tick();
      check("wrap_retcnt", retcnt, exp_q.pop_front());
`ifdef WB_TRACE_EN
      check("trace_valid", tracevalid, 1);
      check("trace_pc", tracepc, 32'h1000 + 32'(4 * i) - 32'h4);
      check("trace_ins", traceins, 32'h2000_0000 | 32'(i));
      check("trace_wdata", tracewdata, rnd);
`endif
    end
    check("wrap_zero", retcnt, 0);
    idle();
    tick();
    check("wrap_bub_hold", retcnt, 0);
`ifdef WB_TRACE_EN
    check("trace_bub_valid", tracevalid, 0);
    check("trace_bub_pc_hold", tracepc, 32'h1000 + 32'(4 * 15) - 32'h4);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog: the directed sequence needs only a few hundred cycles.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end
endmodule
